// File: rtl/oled_spi_capture_if.sv
// Received-byte stream from the OLED SPI capture block.
// The capture block drives as master; the consumer is the slave.
interface oled_spi_capture_if;
  logic [7:0] rxData;
  logic       rxIsData;
  logic       rxValid;
  logic       rxReady;

  modport master (
    output rxData,
    output rxIsData,
    output rxValid,
    input  rxReady
  );

  modport slave (
    input  rxData,
    input  rxIsData,
    input  rxValid,
    output rxReady
  );
endinterface

// File: rtl/oled_spi_capture.sv
// Oversampling OLED SPI receiver: rebuilds MSB-first bytes tagged
// command/data and queues them in a small first-word-fall-through FIFO.
module oled_spi_capture #(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        oled_spi_clk,
  input  logic        oled_spi_data,
  input  logic        oled_dc_n,
  input  logic        oled_reset_n,
  oled_spi_capture_if.master rx,
  output logic        overflow,
  output logic        framingErr,
  output logic [15:0] byteCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [2:0] sclk_q;
  logic [1:0] data_q;
  logic [1:0] dc_q;
  logic [1:0] prst_q;

  // Idle-high sync values keep reset release from looking like an edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_q <= 3'b111;
      data_q <= 2'b00;
      dc_q   <= 2'b11;
      prst_q <= 2'b11;
    end else begin
      sclk_q <= {sclk_q[1:0], oled_spi_clk};
      data_q <= {data_q[0], oled_spi_data};
      dc_q   <= {dc_q[0], oled_dc_n};
      prst_q <= {prst_q[0], oled_reset_n};
    end
  end

  logic sclk_rise;
  logic data_s;
  logic dc_s;
  logic panel_rst;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign data_s    = data_q[1];
  assign dc_s      = dc_q[1];
  assign panel_rst = ~prst_q[1];

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [6:0]    shift_reg, shift_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic          frame_set;
  logic          push;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 7'd0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      idle_cnt  <= idle_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    idle_n    = idle_cnt;
    frame_set = 1'b0;
    push      = 1'b0;
    if (panel_rst) begin
      state_n   = IDLE;
      bit_cnt_n = 3'd0;
      idle_n    = '0;
      frame_set = (state == SHIFT);
    end else if (sclk_rise) begin
      shift_n   = {shift_reg[5:0], data_s};
      idle_n    = '0;
      bit_cnt_n = bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        push    = 1'b1;
        state_n = IDLE;
      end else begin
        state_n = SHIFT;
      end
    end else if (state == SHIFT) begin
      // Fires on the IDLE_TIMEOUT-th edge after the last rise
      if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
        state_n   = IDLE;
        bit_cnt_n = 3'd0;
        idle_n    = '0;
        frame_set = 1'b1;
      end else begin
        idle_n = idle_cnt + IW'(1);
      end
    end
  end

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        accept;
  logic        drop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = ((wr_ptr - rd_ptr) == (AW + 1)'(FIFO_DEPTH));
  assign pop    = ~empty & rx.rxReady;
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= {dc_s, shift_reg, data_s};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      framingErr <= 1'b0;
      byteCount  <= 16'd0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + (AW + 1)'(1);
        byteCount <= byteCount + 16'd1;
      end
      if (pop)       rd_ptr     <= rd_ptr + (AW + 1)'(1);
      if (drop)      overflow   <= 1'b1;
      if (frame_set) framingErr <= 1'b1;
    end
  end

  // Head is masked when empty so stale entries never show
  assign rx.rxValid  = ~empty;
  assign rx.rxData   = empty ? 8'd0 : mem[rd_ptr[AW-1:0]][7:0];
  assign rx.rxIsData = empty ? 1'b0 : mem[rd_ptr[AW-1:0]][8];
endmodule

// File: tb/tb_oled_spi_capture.sv
// Directed bench for oled_spi_capture: latency, string, overflow,
// timeout, panel reset and async reset cases.
module tb_oled_spi_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b1;
  logic        sdata = 1'b0;
  logic        dc = 1'b1;
  logic        prst_n = 1'b1;
  logic        overflow;
  logic        framingErr;
  logic [15:0] byteCount;

  oled_spi_capture_if rx();

  oled_spi_capture #(
    .FIFO_DEPTH(4),
    .IDLE_TIMEOUT(1000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .oled_spi_clk(sclk),
    .oled_spi_data(sdata),
    .oled_dc_n(dc),
    .oled_reset_n(prst_n),
    .rx(rx),
    .overflow(overflow),
    .framingErr(framingErr),
    .byteCount(byteCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [8:0] got[$];
  logic [7:0] shriya [6] = '{8'h53, 8'h68, 8'h72, 8'h69, 8'h79, 8'h61};

  always @(negedge clock)
    if (mon_en && rx.rxValid && rx.rxReady)
      got.push_back({rx.rxIsData, rx.rxData});

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic d);
    sclk = 1'b0; sdata = b; dc = d;
    #50;
    sclk = 1'b1;
    #50;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic d);
    for (int i = 7; i >= 0; i--) send_bit(v[i], d);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] v,
                         input logic d);
    check({tag, "_valid"}, 16'(rx.rxValid), 16'd1);
    check({tag, "_data"}, 16'(rx.rxData), 16'(v));
    check({tag, "_isdata"}, 16'(rx.rxIsData), 16'(d));
    rx.rxReady = 1'b1;
    #10;
    rx.rxReady = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #20;
    reset = 1'b0;
    #20;
  endtask

  initial begin
    logic [7:0] v;
    rx.rxReady = 1'b0;
    #20;
    check("rst_valid", 16'(rx.rxValid), 16'd0);
    check("rst_data", 16'(rx.rxData), 16'd0);
    check("rst_isdata", 16'(rx.rxIsData), 16'd0);
    check("rst_ovf", 16'(overflow), 16'd0);
    check("rst_ferr", 16'(framingErr), 16'd0);
    check("rst_count", byteCount, 16'd0);
    reset = 1'b0;
    #20;

    // 0xA5 command byte, last bit by hand to time rxValid
    v = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b0);
    sclk = 1'b0; sdata = v[0]; dc = 1'b0;
    #50;
    sclk = 1'b1;
    #20;
    check("lat_early", 16'(rx.rxValid), 16'd0);
    #10;
    check("lat_valid", 16'(rx.rxValid), 16'd1);
    check("a5_data", 16'(rx.rxData), 16'h00A5);
    check("a5_isdata", 16'(rx.rxIsData), 16'd0);
    check("a5_count", byteCount, 16'd1);
    #20;
    pop_chk("a5_pop", 8'hA5, 1'b0);
    check("a5_empty", 16'(rx.rxValid), 16'd0);

    // "Shriya" with consumer always ready
    do_reset();
    rx.rxReady = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(shriya[i], 1'b1);
    #50;
    mon_en = 1'b0;
    rx.rxReady = 1'b0;
    check("str_npop", 16'(got.size()), 16'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("str_byte%0d", i),
            (i < got.size()) ? 16'(got[i]) : 16'hFFFF,
            16'({1'b1, shriya[i]}));
    check("str_count", byteCount, 16'd6);
    check("str_ovf", 16'(overflow), 16'd0);
    check("str_empty", 16'(rx.rxValid), 16'd0);

    // Overflow, then simultaneous push and pop while full
    do_reset();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    check("ovf_flag", 16'(overflow), 16'd1);
    check("ovf_count", byteCount, 16'd4);
    v = 8'h06;
    for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b1);
    sclk = 1'b0; sdata = v[0]; dc = 1'b1;
    #50;
    sclk = 1'b1;
    #20;
    rx.rxReady = 1'b1;
    #10;
    rx.rxReady = 1'b0;
    #20;
    check("pp_count", byteCount, 16'd5);
    pop_chk("pp_02", 8'h02, 1'b1);
    pop_chk("pp_03", 8'h03, 1'b1);
    pop_chk("pp_04", 8'h04, 1'b1);
    pop_chk("pp_06", 8'h06, 1'b1);
    check("pp_empty", 16'(rx.rxValid), 16'd0);

    // Timeout after 3 bits: fires exactly 1000 cycles after the last rise
    do_reset();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    #9970;
    check("to_before", 16'(framingErr), 16'd0);
    #10;
    check("to_after", 16'(framingErr), 16'd1);
    send_byte(8'h3C, 1'b1);
    check("to_valid", 16'(rx.rxValid), 16'd1);
    check("to_data", 16'(rx.rxData), 16'h003C);
    check("to_count", byteCount, 16'd1);

    // Panel reset after 5 bits keeps earlier FIFO contents
    do_reset();
    send_byte(8'h11, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    check("pr_before", 16'(framingErr), 16'd0);
    prst_n = 1'b0;
    #100;
    prst_n = 1'b1;
    #100;
    check("pr_ferr", 16'(framingErr), 16'd1);
    send_byte(8'hFF, 1'b0);
    check("pr_count", byteCount, 16'd2);
    pop_chk("pr_11", 8'h11, 1'b1);
    pop_chk("pr_ff", 8'hFF, 1'b0);
    check("pr_empty", 16'(rx.rxValid), 16'd0);

    // Async reset mid-byte with a non-empty FIFO
    do_reset();
    send_byte(8'h22, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
    check("ar_pre", 16'(rx.rxValid), 16'd1);
    #3;
    reset = 1'b1;
    #1;
    check("ar_valid", 16'(rx.rxValid), 16'd0);
    check("ar_data", 16'(rx.rxData), 16'd0);
    check("ar_count", byteCount, 16'd0);
    check("ar_ovf", 16'(overflow), 16'd0);
    #6;
    #10;
    reset = 1'b0;
    #50;
    send_byte(8'h5A, 1'b0);
    check("ar_new_data", 16'(rx.rxData), 16'h005A);
    check("ar_new_isdata", 16'(rx.rxIsData), 16'd0);
    check("ar_new_count", byteCount, 16'd1);
    check("ar_new_ferr", 16'(framingErr), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
